// File: rtl/soda_machine_controller_if.sv
// Signal bundle between the soda machine controller, the coin acceptor/dispenser
// I/O and the total/compare datapath. The controller uses the master modport.
interface soda_machine_controller_if;
    logic c;
    logic tot_lt_s;
    logic s_eq_zero;
    logic tot_ld;
    logic tot_clr;
    logic d;
    logic oos;
    logic coin_rej;
    logic refund;

    modport master (
        input  c, tot_lt_s, s_eq_zero,
        output tot_ld, tot_clr, d, oos, coin_rej, refund
    );

    modport slave (
        output c, tot_lt_s, s_eq_zero,
        input  tot_ld, tot_clr, d, oos, coin_rej, refund
    );
endinterface

// File: rtl/soda_machine_controller.sv
// Moore FSM sequencing the soda machine total/compare datapath.
// Define SODA_TIMEOUT_EN to refund idle credit after TIMEOUT_CYCLES cycles.
module soda_machine_controller #(
    parameter int unsigned DISP_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 16
) (
    input logic clk,
    input logic rst,
    soda_machine_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_INIT,
        S_WAIT,
        S_ADD,
        S_DISP,
        S_OOS
`ifdef SODA_TIMEOUT_EN
        , S_REFUND
`endif
    } state_t;

    localparam int unsigned      CNT_MAX_I = (DISP_CYCLES > TIMEOUT_CYCLES) ? DISP_CYCLES
                                                                              : TIMEOUT_CYCLES;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CNT_MAX_I);
    localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISP_CYCLES - 1);
`ifdef SODA_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             c_q;
    logic             pend_q, pend_d;
    logic             credit_q, credit_d;
    logic             coin_rej_q;
    logic             rise;

    assign rise    = bus.c & ~c_q;
    // Saturate so a misconfigured CNT_W can never wrap back into a matching count.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            cnt_q      <= '0;
            c_q        <= 1'b0;
            pend_q     <= 1'b0;
            credit_q   <= 1'b0;
            coin_rej_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            c_q        <= bus.c;
            pend_q     <= pend_d;
            credit_q   <= credit_d;
            coin_rej_q <= rise & ((state_q == S_DISP) | (state_q == S_OOS));
        end
    end

    // NOTE: every signal gets its hold value first so no path through the case
    // leaves one unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        credit_d = credit_q;
        case (state_q)
            S_INIT: begin
                credit_d = 1'b0;
                cnt_d    = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (bus.s_eq_zero) begin
                    state_d = S_OOS;
                end else if (rise | pend_q) begin
                    state_d = S_ADD;
                    pend_d  = 1'b0;
                end else if (!bus.tot_lt_s && credit_q) begin
                    state_d = S_DISP;
                    cnt_d   = '0;
`ifdef SODA_TIMEOUT_EN
                end else if (credit_q) begin
                    if (cnt_q == TIMEOUT_LAST) state_d = S_REFUND;
                    else                       cnt_d   = cnt_inc;
`endif
                end
            end
            S_ADD: begin
                credit_d = 1'b1;
                cnt_d    = '0;
                state_d  = S_WAIT;
                if (rise) pend_d = 1'b1;
            end
            S_DISP: begin
                if (cnt_q == DISP_LAST) state_d = S_INIT;
                else                    cnt_d   = cnt_inc;
            end
            S_OOS: begin
                // The total is left untouched so credit survives a price reload.
                if (!bus.s_eq_zero) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
`ifdef SODA_TIMEOUT_EN
            S_REFUND: state_d = S_INIT;
`endif
            default: state_d = S_INIT;
        endcase
    end

    assign bus.tot_clr  = (state_q == S_INIT);
    assign bus.tot_ld   = (state_q == S_ADD);
    assign bus.d        = (state_q == S_DISP);
    assign bus.oos      = (state_q == S_OOS);
    assign bus.coin_rej = coin_rej_q;
`ifdef SODA_TIMEOUT_EN
    assign bus.refund   = (state_q == S_REFUND);
`else
    assign bus.refund   = 1'b0;
`endif

endmodule

// File: tb/tb_soda_machine_controller.sv
// Directed bench for soda_machine_controller with a behavioural total/price datapath.
// Build with SODA_TIMEOUT_EN defined to exercise the refund path.
module tb_soda_machine_controller;

    localparam int unsigned DISP_CYCLES    = 4;
    localparam int unsigned TIMEOUT_CYCLES = 8;
    localparam int          BUDGET         = 40;

    logic clk = 1'b0;
    logic rst;

    int total    = 0;
    int price    = 0;
    int coin_val = 0;
    int c_hold   = 0;
    int vec_cnt  = 0;
    int miss_cnt = 0;
    int ld_cnt   = 0;
    int d_cnt    = 0;
    int rej_cnt  = 0;
    int ref_cnt  = 0;

    soda_machine_controller_if bus();

    soda_machine_controller #(
        .DISP_CYCLES   (DISP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: total register plus comparators against the price.
    assign bus.tot_lt_s  = (total < price);
    assign bus.s_eq_zero = (price == 0);

    always @(posedge clk) begin
        if (bus.tot_clr)     total <= 0;
        else if (bus.tot_ld) total <= total + coin_val;
    end

    always @(negedge clk) begin
        if (bus.tot_ld   === 1'b1) ld_cnt  <= ld_cnt + 1;
        if (bus.d        === 1'b1) d_cnt   <= d_cnt + 1;
        if (bus.coin_rej === 1'b1) rej_cnt <= rej_cnt + 1;
        if (bus.refund   === 1'b1) ref_cnt <= ref_cnt + 1;
    end

    function automatic logic [5:0] outs();
        return {bus.tot_clr, bus.tot_ld, bus.d, bus.oos, bus.coin_rej, bus.refund};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (c_hold > 0) begin
            c_hold--;
            if (c_hold == 0) bus.c = 1'b0;
        end
    endtask

    task automatic coin(input int value, input int hold);
        coin_val = value;
        bus.c    = 1'b1;
        c_hold   = hold;
    endtask

    task automatic wait_d_high(output int lat);
        lat = 0;
        while (bus.d !== 1'b1 && lat < BUDGET) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_d_low(output int len);
        len = 0;
        while (bus.d === 1'b1 && len < BUDGET) begin
            tick();
            len++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        bus.c = 1'b0;
        price = 50;
        tick();
        tick();
        vec_cnt++;
        if (outs() !== 6'b100000) begin
            miss_cnt++;
            $display("FAIL reset_outs: got %b want 100000", outs());
        end
        vec_cnt++;
        if (total !== 0) begin
            miss_cnt++;
            $display("FAIL reset_total: got %0d want 0", total);
        end
        rst = 1'b0;
        tick();
        tick();
        vec_cnt++;
        if (outs() !== 6'b000000) begin
            miss_cnt++;
            $display("FAIL reset_idle_outs: got %b want 000000", outs());
        end
    endtask

    task automatic test_two_coins();
        int ld0, lat, len;
        ld0 = ld_cnt;
        coin(25, 3);
        repeat (8) tick();
        vec_cnt++;
        if (total !== 25) begin
            miss_cnt++;
            $display("FAIL two_coins_total1: got %0d want 25", total);
        end
        vec_cnt++;
        if (ld_cnt - ld0 !== 1) begin
            miss_cnt++;
            $display("FAIL two_coins_ld1: got %0d want 1", ld_cnt - ld0);
        end
        coin(25, 3);
        wait_d_high(lat);
        vec_cnt++;
        if (lat !== 3) begin
            miss_cnt++;
            $display("FAIL two_coins_latency: got %0d want 3", lat);
        end
        wait_d_low(len);
        vec_cnt++;
        if (len !== DISP_CYCLES) begin
            miss_cnt++;
            $display("FAIL two_coins_d_len: got %0d want %0d", len, DISP_CYCLES);
        end
        vec_cnt++;
        if (bus.tot_clr !== 1'b1) begin
            miss_cnt++;
            $display("FAIL two_coins_clr: got %b want 1", bus.tot_clr);
        end
        tick();
        vec_cnt++;
        if (total !== 0) begin
            miss_cnt++;
            $display("FAIL two_coins_total_end: got %0d want 0", total);
        end
        vec_cnt++;
        if (ld_cnt - ld0 !== 2) begin
            miss_cnt++;
            $display("FAIL two_coins_ld2: got %0d want 2", ld_cnt - ld0);
        end
    endtask

    task automatic test_overpay();
        int ld0, lat, len;
        ld0   = ld_cnt;
        price = 30;
        coin(50, 1);
        wait_d_high(lat);
        vec_cnt++;
        if (lat !== 3) begin
            miss_cnt++;
            $display("FAIL overpay_latency: got %0d want 3", lat);
        end
        wait_d_low(len);
        vec_cnt++;
        if (len !== DISP_CYCLES) begin
            miss_cnt++;
            $display("FAIL overpay_d_len: got %0d want %0d", len, DISP_CYCLES);
        end
        tick();
        vec_cnt++;
        if (total !== 0) begin
            miss_cnt++;
            $display("FAIL overpay_total: got %0d want 0", total);
        end
        vec_cnt++;
        if (ld_cnt - ld0 !== 1) begin
            miss_cnt++;
            $display("FAIL overpay_ld: got %0d want 1", ld_cnt - ld0);
        end
    endtask

    task automatic test_out_of_service();
        int ld0, lat, len;
        price = 0;
        tick();
        tick();
        vec_cnt++;
        if (bus.oos !== 1'b1) begin
            miss_cnt++;
            $display("FAIL oos_enter: got %b want 1", bus.oos);
        end
        ld0 = ld_cnt;
        coin(25, 2);
        tick();
        vec_cnt++;
        if (bus.coin_rej !== 1'b1) begin
            miss_cnt++;
            $display("FAIL oos_rej_pulse: got %b want 1", bus.coin_rej);
        end
        tick();
        vec_cnt++;
        if (bus.coin_rej !== 1'b0) begin
            miss_cnt++;
            $display("FAIL oos_rej_end: got %b want 0", bus.coin_rej);
        end
        vec_cnt++;
        if (ld_cnt - ld0 !== 0 || total !== 0) begin
            miss_cnt++;
            $display("FAIL oos_no_credit: got ld %0d total %0d want 0 0", ld_cnt - ld0, total);
        end
        price = 40;
        tick();
        vec_cnt++;
        if (bus.oos !== 1'b0) begin
            miss_cnt++;
            $display("FAIL oos_exit: got %b want 0", bus.oos);
        end
        coin(40, 1);
        wait_d_high(lat);
        vec_cnt++;
        if (lat !== 3) begin
            miss_cnt++;
            $display("FAIL oos_vend_latency: got %0d want 3", lat);
        end
        wait_d_low(len);
        tick();
        vec_cnt++;
        if (total !== 0) begin
            miss_cnt++;
            $display("FAIL oos_vend_total: got %0d want 0", total);
        end
    endtask

    task automatic test_coin_during_disp();
        int ld0, d0, rej0, lat, len;
        ld0   = ld_cnt;
        d0    = d_cnt;
        rej0  = rej_cnt;
        price = 10;
        coin(10, 1);
        wait_d_high(lat);
        vec_cnt++;
        if (lat !== 3) begin
            miss_cnt++;
            $display("FAIL disp_rej_latency: got %0d want 3", lat);
        end
        tick();
        coin(10, 1);
        tick();
        vec_cnt++;
        if (bus.coin_rej !== 1'b1 || bus.d !== 1'b1) begin
            miss_cnt++;
            $display("FAIL disp_rej_pulse: got rej %b d %b want 1 1", bus.coin_rej, bus.d);
        end
        tick();
        vec_cnt++;
        if (bus.coin_rej !== 1'b0) begin
            miss_cnt++;
            $display("FAIL disp_rej_end: got %b want 0", bus.coin_rej);
        end
        wait_d_low(len);
        tick();
        vec_cnt++;
        if (total !== 0) begin
            miss_cnt++;
            $display("FAIL disp_rej_total: got %0d want 0", total);
        end
        repeat (10) tick();
        vec_cnt++;
        if (d_cnt - d0 !== DISP_CYCLES || rej_cnt - rej0 !== 1 || ld_cnt - ld0 !== 1) begin
            miss_cnt++;
            $display("FAIL disp_rej_counts: got d %0d rej %0d ld %0d want %0d 1 1",
                     d_cnt - d0, rej_cnt - rej0, ld_cnt - ld0, DISP_CYCLES);
        end
    endtask

    task automatic test_reset_mid_disp();
        int d0, lat;
        d0    = d_cnt;
        price = 10;
        coin(10, 1);
        wait_d_high(lat);
        tick();
        rst = 1'b1;
        tick();
        vec_cnt++;
        if (outs() !== 6'b100000) begin
            miss_cnt++;
            $display("FAIL rst_disp_outs: got %b want 100000", outs());
        end
        rst = 1'b0;
        tick();
        vec_cnt++;
        if (total !== 0) begin
            miss_cnt++;
            $display("FAIL rst_disp_total: got %0d want 0", total);
        end
        repeat (10) tick();
        vec_cnt++;
        if (d_cnt - d0 !== 2) begin
            miss_cnt++;
            $display("FAIL rst_disp_d_cycles: got %0d want 2", d_cnt - d0);
        end
    endtask

    task automatic test_coin_priority();
        int ld0, lat, len;
        price = 50;
        coin(30, 1);
        repeat (4) tick();
        vec_cnt++;
        if (total !== 30) begin
            miss_cnt++;
            $display("FAIL prio_credit: got %0d want 30", total);
        end
        ld0   = ld_cnt;
        price = 20;
        coin(10, 1);
        wait_d_high(lat);
        vec_cnt++;
        if (lat !== 3 || ld_cnt - ld0 !== 1) begin
            miss_cnt++;
            $display("FAIL prio_coin_first: got lat %0d ld %0d want 3 1", lat, ld_cnt - ld0);
        end
        wait_d_low(len);
        tick();
        vec_cnt++;
        if (total !== 0) begin
            miss_cnt++;
            $display("FAIL prio_total: got %0d want 0", total);
        end
    endtask

    task automatic test_timeout();
        int ref0;
        ref0  = ref_cnt;
        price = 50;
        coin(20, 1);
        tick();
        tick();
`ifdef SODA_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (bus.refund !== 1'b1 && n < BUDGET) begin
                tick();
                n++;
            end
            vec_cnt++;
            if (n !== TIMEOUT_CYCLES) begin
                miss_cnt++;
                $display("FAIL timeout_latency: got %0d want %0d", n, TIMEOUT_CYCLES);
            end
            tick();
            vec_cnt++;
            if (bus.tot_clr !== 1'b1 || bus.refund !== 1'b0) begin
                miss_cnt++;
                $display("FAIL timeout_clr: got clr %b refund %b want 1 0", bus.tot_clr, bus.refund);
            end
            tick();
            vec_cnt++;
            if (total !== 0 || ref_cnt - ref0 !== 1) begin
                miss_cnt++;
                $display("FAIL timeout_total: got total %0d refunds %0d want 0 1", total, ref_cnt - ref0);
            end
        end
`else
        repeat (100) tick();
        vec_cnt++;
        if (ref_cnt - ref0 !== 0 || bus.refund !== 1'b0) begin
            miss_cnt++;
            $display("FAIL no_timeout_refund: got %0d want 0", ref_cnt - ref0);
        end
        vec_cnt++;
        if (total !== 20) begin
            miss_cnt++;
            $display("FAIL no_timeout_total: got %0d want 20", total);
        end
`endif
    endtask

    initial begin
        bus.c = 1'b0;
        rst   = 1'b1;
        test_reset();
        test_two_coins();
        test_overpay();
        test_out_of_service();
        test_coin_during_disp();
        test_reset_mid_disp();
        test_coin_priority();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
